// File: rtl/mem_responder.sv
// mem_responder: word memory with a fixed-latency busy/ready handshake and access counters.
// Optional ERR_INJECT_EN flips ERR_MASK bits in read data returned for ERR_ADDR.
`default_nettype none

module mem_responder #(
  parameter int                    ADDR_WIDTH  = 10,
  parameter int                    LATENCY     = 2,
  parameter int                    INIT_CYCLES = 16,
  parameter logic [ADDR_WIDTH-1:0] ERR_ADDR    = '0,
  parameter logic [15:0]           ERR_MASK    = 16'h0001
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_enable_i,
  input  logic                  rd_enable_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [15:0]           wr_data_i,
  output logic                  busy_o,
  output logic                  rd_ready_o,
  output logic [15:0]           rd_data_o,
  output logic [15:0]           wr_count_o,
  output logic [15:0]           rd_count_o
);

  localparam logic [1:0] S_INIT   = 2'd0;
  localparam logic [1:0] S_IDLE   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [5:0] INIT_LOAD = 6'(INIT_CYCLES - 1);
  localparam logic [3:0] LAT_LOAD  = 4'(LATENCY - 1);

  logic [1:0]            state_q, state_d;
  logic [5:0]            init_cnt_q, init_cnt_d;
  logic [3:0]            lat_cnt_q, lat_cnt_d;
  logic                  op_wr_q, op_wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           data_q, data_d;
  logic                  busy_q, busy_d;
  logic                  rd_ready_q, rd_ready_d;
  logic [15:0]           rd_data_q, rd_data_d;
  logic [15:0]           wr_count_q, wr_count_d;
  logic [15:0]           rd_count_q, rd_count_d;
  logic                  mem_we;
  logic [15:0]           err_mask;

  logic [15:0] mem_q [2**ADDR_WIDTH];

`ifdef ERR_INJECT_EN
  assign err_mask = (addr_q == ERR_ADDR) ? ERR_MASK : 16'h0000;
`else
  logic unused_cfg;
  assign unused_cfg = ^{ERR_ADDR, ERR_MASK};
  assign err_mask   = 16'h0000;
`endif

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    op_wr_d    = op_wr_q;
    addr_d     = addr_q;
    data_d     = data_q;
    busy_d     = busy_q;
    rd_ready_d = 1'b0;
    rd_data_d  = rd_data_q;
    wr_count_d = wr_count_q;
    rd_count_d = rd_count_q;
    mem_we     = 1'b0;
    case (state_q)
      S_INIT: begin
        if (init_cnt_q == 6'd0) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          init_cnt_d = init_cnt_q - 6'd1;
        end
      end
      S_IDLE: begin
        // Write wins when both enables are seen together.
        if (wr_enable_i || rd_enable_i) begin
          op_wr_d   = wr_enable_i;
          addr_d    = addr_i;
          data_d    = wr_data_i;
          lat_cnt_d = LAT_LOAD;
          state_d   = S_ACCESS;
          busy_d    = 1'b1;
        end
      end
      S_ACCESS: begin
        if (lat_cnt_q == 4'd0) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          if (op_wr_q) begin
            mem_we     = 1'b1;
            wr_count_d = (wr_count_q == 16'hFFFF) ? wr_count_q : wr_count_q + 16'd1;
          end else begin
            rd_ready_d = 1'b1;
            rd_data_d  = mem_q[addr_q] ^ err_mask;
            rd_count_d = (rd_count_q == 16'hFFFF) ? rd_count_q : rd_count_q + 16'd1;
          end
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_INIT;
      init_cnt_q <= INIT_LOAD;
      lat_cnt_q  <= 4'd0;
      op_wr_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= 16'h0000;
      busy_q     <= 1'b1;
      rd_ready_q <= 1'b0;
      rd_data_q  <= 16'h0000;
      wr_count_q <= 16'h0000;
      rd_count_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      op_wr_q    <= op_wr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      rd_ready_q <= rd_ready_d;
      rd_data_q  <= rd_data_d;
      wr_count_q <= wr_count_d;
      rd_count_q <= rd_count_d;
    end
  end

  // Array is never cleared; reset only blocks a write that has not yet committed.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem_q[addr_q] <= data_q;
    end
  end

  assign busy_o     = busy_q;
  assign rd_ready_o = rd_ready_q;
  assign rd_data_o  = rd_data_q;
  assign wr_count_o = wr_count_q;
  assign rd_count_o = rd_count_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized and directed checks of mem_responder against a behavioural memory model.
`default_nettype none

module tb_mem_responder;

  localparam int          AW          = 10;
  localparam int          DEPTH       = 1 << AW;
  localparam int          LATENCY     = 2;
  localparam int          INIT_CYCLES = 16;
  localparam logic [9:0]  T_ERR_ADDR  = 10'd4;
  localparam logic [15:0] T_ERR_MASK  = 16'h0001;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_enable_i = 1'b0;
  logic          rd_enable_i = 1'b0;
  logic [AW-1:0] addr_i = '0;
  logic [15:0]   wr_data_i = 16'h0000;
  logic          busy_o;
  logic          rd_ready_o;
  logic [15:0]   rd_data_o;
  logic [15:0]   wr_count_o;
  logic [15:0]   rd_count_o;

  mem_responder #(
    .ADDR_WIDTH (AW),
    .LATENCY    (LATENCY),
    .INIT_CYCLES(INIT_CYCLES),
    .ERR_ADDR   (T_ERR_ADDR),
    .ERR_MASK   (T_ERR_MASK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_enable_i(wr_enable_i),
    .rd_enable_i(rd_enable_i),
    .addr_i     (addr_i),
    .wr_data_i  (wr_data_i),
    .busy_o     (busy_o),
    .rd_ready_o (rd_ready_o),
    .rd_data_o  (rd_data_o),
    .wr_count_o (wr_count_o),
    .rd_count_o (rd_count_o)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: stored words, which words are defined, and expected observables.
  logic [15:0] m_mem [DEPTH];
  bit          m_valid [DEPTH];
  int          m_wr_cnt = 0;
  int          m_rd_cnt = 0;
  int          m_rd_total = 0;
  logic [15:0] m_last_rd = 16'h0000;
  int          pulses_seen = 0;

  always @(negedge clk) if (rd_ready_o === 1'b1) pulses_seen++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_read(input int a);
    logic [15:0] v;
    v = m_mem[a];
`ifdef ERR_INJECT_EN
    if (a == int'(T_ERR_ADDR)) v = v ^ T_ERR_MASK;
`endif
    return v;
  endfunction

  // Called on a falling edge; leaves the DUT idle after its init period.
  task automatic do_reset();
    int n;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", busy_o, 1'b1);
    check_eq("rst_rd_ready", rd_ready_o, 1'b0);
    check_eq("rst_rd_data", rd_data_o, 16'h0000);
    check_eq("rst_wr_count", wr_count_o, 16'h0000);
    check_eq("rst_rd_count", rd_count_o, 16'h0000);
    m_wr_cnt  = 0;
    m_rd_cnt  = 0;
    m_last_rd = 16'h0000;
    rst_n = 1'b1;
    n = 0;
    while (busy_o && n < 200) begin
      n++;
      @(negedge clk);
    end
    check_eq("init_busy_cycles", n, INIT_CYCLES);
    check_eq("init_rd_count", rd_count_o, 16'h0000);
  endtask

  task automatic do_op(input bit wr, input bit rd, input int a, input logic [15:0] d);
    int  n;
    bit  is_rd;
    @(negedge clk);
    wr_enable_i = wr;
    rd_enable_i = rd;
    addr_i      = AW'(a);
    wr_data_i   = d;
    n = 0;
    @(negedge clk);
    while (!busy_o && n < 20) begin
      n++;
      @(negedge clk);
    end
    wr_enable_i = 1'b0;
    rd_enable_i = 1'b0;
    if (!busy_o) begin
      check_eq("accept_timeout", 1'b0, 1'b1);
      return;
    end
    n = 0;
    while (busy_o && n < 40) begin
      n++;
      @(negedge clk);
    end
    check_eq("busy_len", n, LATENCY);
    is_rd = rd && !wr;
    if (wr) begin
      m_mem[a]   = d;
      m_valid[a] = 1'b1;
      if (m_wr_cnt < 65535) m_wr_cnt++;
    end else begin
      if (m_rd_cnt < 65535) m_rd_cnt++;
      m_rd_total++;
      m_last_rd = model_read(a);
    end
    check_eq(is_rd ? "rd_ready_done" : "wr_no_rd_ready", rd_ready_o, is_rd);
    check_eq(is_rd ? "rd_data" : "rd_data_hold", rd_data_o, m_last_rd);
    check_eq("wr_count", wr_count_o, 16'(m_wr_cnt));
    check_eq("rd_count", rd_count_o, 16'(m_rd_cnt));
    @(negedge clk);
    check_eq("rd_ready_one_cycle", rd_ready_o, 1'b0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int kind;
    int a;
    logic [15:0] d;
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;

    @(negedge clk);
    do_reset();
    repeat (4) @(negedge clk);
    check_eq("idle_busy_low", busy_o, 1'b0);
    check_eq("no_pulse_after_init", pulses_seen, 0);

    do_op(1'b1, 1'b0, 3, 16'hA5A5);
    check_eq("wr_count_first", wr_count_o, 16'd1);
    do_op(1'b0, 1'b1, 3, 16'h0000);
    check_eq("rd_data_a5a5", rd_data_o, 16'hA5A5);

    do_op(1'b1, 1'b1, 5, 16'h1234);
    check_eq("both_wr_count", wr_count_o, 16'd2);
    check_eq("both_rd_count", rd_count_o, 16'd1);
    do_op(1'b0, 1'b1, 5, 16'h0000);

    do_op(1'b1, 1'b0, 4, 16'h0010);
    do_op(1'b0, 1'b1, 4, 16'h0000);
`ifdef ERR_INJECT_EN
    check_eq("err_inject_rd", rd_data_o, 16'h0011);
`else
    check_eq("no_err_inject_rd", rd_data_o, 16'h0010);
`endif

    // Reset lands in the first ACCESS cycle, before the write can commit.
    do_op(1'b1, 1'b0, 7, 16'h0007);
    @(negedge clk);
    wr_enable_i = 1'b1;
    addr_i      = 10'd7;
    wr_data_i   = 16'hFFFF;
    a = 0;
    @(negedge clk);
    while (!busy_o && a < 20) begin
      a++;
      @(negedge clk);
    end
    wr_enable_i = 1'b0;
    check_eq("abort_in_access", busy_o, 1'b1);
    do_reset();
    do_op(1'b0, 1'b1, 7, 16'h0000);
    check_eq("abort_kept_old", rd_data_o, 16'h0007);

    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 2);
      a    = $urandom_range(0, 31);
      d    = 16'($urandom);
      if (kind == 1 && !m_valid[a]) kind = 0;
      do_op(kind != 1, kind != 0, a, d);
    end

    @(negedge clk);
    do_reset();
    for (int i = 0; i < DEPTH; i++) do_op(1'b1, 1'b0, i, 16'(i) ^ 16'h5A5A);
    for (int i = 0; i < DEPTH; i++) do_op(1'b0, 1'b1, i, 16'h0000);
    check_eq("sweep_last_addr", rd_data_o, 16'h03FF ^ 16'h5A5A);
    check_eq("sweep_wr_count", wr_count_o, 16'd1024);
    check_eq("sweep_rd_count", rd_count_o, 16'd1024);
    check_eq("total_pulses", pulses_seen, m_rd_total);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
